uart_frame_packer: RTL and testbench

UART_FRAME_PACKER -- requirements
Module: uart_frame_packer

---
 rtl/uart_frame_packer.sv | 132 +++++++++++++
 tb/tb_uart_frame_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_packer.sv
// Frames a latched payload as HDR0 HDR1 CMD LEN payload CRC TAIL and streams
// it one byte at a time over a valid/ready write port (wr_en / wr_ready).
module uart_frame_packer #(
  parameter int         MAX_LEN  = 26,
  parameter logic [7:0] HDR0     = 8'h55,
  parameter logic [7:0] HDR1     = 8'hBB,
  parameter logic [7:0] CMD      = 8'h03,
  parameter logic [7:0] TAIL     = 8'hF0,
  parameter logic [7:0] CRC_POLY = 8'h07,
  parameter logic [7:0] CRC_INIT = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           len,
  input  logic [MAX_LEN*8-1:0] payload,
  input  logic                 wr_ready,
  output logic                 wr_en,
  output logic [7:0]           wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 drop
);

  localparam int CW = $clog2(MAX_LEN + 7);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        idx;
  logic [CW-1:0]        len_q;
  logic [MAX_LEN*8-1:0] payload_q;
  logic [7:0]           crc_q;

  logic [CW-1:0] len_cap;
  logic [CW-1:0] next_idx;
  logic          cur_covered;
  logic          cur_tail;
  logic          next_is_payload;
  logic [7:0]    crc_after;
  logic [7:0]    next_byte;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    return c;
  endfunction

  // crc_after folds in the byte being accepted now, so the CRC byte can be
  // loaded on the same edge that accepts the last covered byte.
  always_comb begin
    len_cap         = (len > 8'(MAX_LEN)) ? CW'(MAX_LEN) : CW'(len);
    next_idx        = idx + CW'(1);
    cur_covered     = (idx >= CW'(2)) && (idx <= len_q + CW'(3));
    cur_tail        = (idx == len_q + CW'(5));
    next_is_payload = (next_idx >= CW'(4)) && (next_idx <= len_q + CW'(3));
    crc_after       = cur_covered ? crc8_step(crc_q, wr_data) : crc_q;

    if (next_idx == CW'(1))
      next_byte = HDR1;
    else if (next_idx == CW'(2))
      next_byte = CMD;
    else if (next_idx == CW'(3))
      next_byte = 8'(len_q);
    else if (next_is_payload)
      next_byte = payload_q[7:0];
    else if (next_idx == len_q + CW'(4))
      next_byte = crc_after;
    else
      next_byte = TAIL;
  end

  // Payload is kept in a shift register so the next payload byte is always
  // the low byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      len_q     <= '0;
      payload_q <= '0;
      crc_q     <= CRC_INIT;
      wr_en     <= 1'b0;
      wr_data   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      drop      <= 1'b0;
    end else begin
      done <= 1'b0;
      drop <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SEND;
            idx       <= '0;
            len_q     <= len_cap;
            payload_q <= payload;
            crc_q     <= CRC_INIT;
            wr_en     <= 1'b1;
            wr_data   <= HDR0;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          if (start) drop <= 1'b1;
          if (wr_ready) begin
            crc_q <= crc_after;
            if (cur_tail) begin
              state   <= DONE;
              wr_en   <= 1'b0;
              wr_data <= 8'h00;
              done    <= 1'b1;
            end else begin
              idx     <= next_idx;
              wr_data <= next_byte;
              if (next_is_payload) payload_q <= payload_q >> 8;
            end
          end
        end
        DONE: begin
          if (start) drop <= 1'b1;
          state <= IDLE;
          idx   <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Bench for uart_frame_packer: table of frames plus hand-written drop and
// reset-abort sequences, with a byte scoreboard fed by a reference model.
module tb_uart_frame_packer;

  localparam int MAX_LEN = 26;
  localparam int PW      = MAX_LEN * 8;

  typedef struct {
    logic [7:0] len;
    logic [7:0] seed;
    int         stall_at;
    int         stall_len;
    logic [7:0] exp_len_byte;
    int         exp_total;
  } vec_t;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          start    = 1'b0;
  logic [7:0]    len      = 8'h00;
  logic [PW-1:0] payload  = '0;
  logic          wr_ready = 1'b1;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic          drop;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  int         acc_cyc[$];
  int         cyc        = 0;
  int         done_cnt   = 0;
  int         drop_cnt   = 0;
  int         stall_at   = -1;
  int         stall_left = 0;
  logic       prev_en    = 1'b0;
  logic       prev_rdy   = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always #5 clk = ~clk;

  uart_frame_packer #(.MAX_LEN(MAX_LEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .len     (len),
    .payload (payload),
    .wr_ready(wr_ready),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .drop    (drop)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  // Bit-serial CRC-8 reference, MSB first.
  function automatic logic [7:0] crc_model(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] r;
    logic       fb;
    r = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ data[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] make_payload(input logic [7:0] seed);
    logic [PW-1:0] p;
    for (int k = 0; k < MAX_LEN; k++) p[k*8 +: 8] = seed + 8'(k * 59);
    return p;
  endfunction

  task automatic push_model(input logic [7:0] l, input logic [PW-1:0] p);
    logic [7:0] c;
    logic [7:0] b;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'h03);
    exp_q.push_back(l);
    c = crc_model(8'h00, 8'h03);
    c = crc_model(c, l);
    for (int k = 0; k < int'(l); k++) begin
      b = p[k*8 +: 8];
      exp_q.push_back(b);
      c = crc_model(c, b);
    end
    exp_q.push_back(c);
    exp_q.push_back(8'hF0);
  endtask

  // One-cycle start pulse, then scramble the inputs to prove they were latched.
  task automatic applyStimulus(input logic [7:0] l, input logic [PW-1:0] p);
    @(posedge clk); #1;
    start   = 1'b1;
    len     = l;
    payload = p;
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'($urandom);
    for (int k = 0; k < MAX_LEN; k++) payload[k*8 +: 8] = 8'($urandom);
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (done !== 1'b1 && i < 500) begin
      @(posedge clk); #1;
      i++;
    end
    if (i >= 500) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles required done", i);
    end
  endtask

  task automatic run_expect(input logic [7:0] l, input logic [PW-1:0] p, input int n, input int stall);
    int d0;
    acc_cyc.delete();
    d0 = done_cnt;
    applyStimulus(l, p);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_pulses", done_cnt - d0, 1);
    checkOutput("busy_after", 32'(busy), 32'(0));
    checkOutput("frame_len", acc_cyc.size(), n);
    checkOutput("frame_span", (acc_cyc.size() > 0) ? acc_cyc[$] - acc_cyc[0] : -1, n - 1 + stall);
    checkOutput("sb_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && wr_en && acc_cyc.size() == stall_at) begin
      wr_ready = 1'b0;
      stall_left--;
    end else begin
      wr_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!wr_en) checkOutput("idle_data", 32'(wr_data), 32'(0));
    if (reset && prev_en && !prev_rdy && wr_en) checkOutput("stall_hold", 32'(wr_data), 32'(prev_data));
    if (wr_en && wr_ready) begin
      acc_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL extra_byte: got %02h required no byte", wr_data);
      end else begin
        checkOutput("frame_byte", 32'(wr_data), 32'(exp_q.pop_front()));
      end
    end
    if (done) begin
      done_cnt++;
      checkOutput("busy_in_done", 32'(busy), 32'(1));
    end
    if (drop) drop_cnt++;
    prev_en   = wr_en;
    prev_rdy  = wr_ready;
    prev_data = wr_data;
  end

  initial begin
    vec_t          vecs[8];
    logic [PW-1:0] p;
    int            d0;
    int            r0;
    int            i;

    vecs[0] = '{8'd1,   8'h00, -1, 0, 8'h01, 7};
    vecs[1] = '{8'd0,   8'h9C, -1, 0, 8'h00, 6};
    vecs[2] = '{8'd5,   8'h11,  3, 5, 8'h05, 11};
    vecs[3] = '{8'd5,   8'h11, -1, 0, 8'h05, 11};
    vecs[4] = '{8'd200, 8'hA5, -1, 0, 8'h1A, 32};
    vecs[5] = '{8'd26,  8'h7E, 10, 3, 8'h1A, 32};
    vecs[6] = '{8'd27,  8'h33, -1, 0, 8'h1A, 32};
    vecs[7] = '{8'd26,  8'hC3, 31, 2, 8'h1A, 32};

    #1 reset = 1'b0;
    #3;
    checkOutput("rst_wr_en", 32'(wr_en), 32'(0));
    checkOutput("rst_wr_data", 32'(wr_data), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_drop", 32'(drop), 32'(0));
    #19 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Literal frames for len=1 (payload 00) and len=0.
    p = '0;
    exp_q.push_back(8'h55); exp_q.push_back(8'hBB); exp_q.push_back(8'h03); exp_q.push_back(8'h01);
    exp_q.push_back(8'h00); exp_q.push_back(8'hA8); exp_q.push_back(8'hF0);
    run_expect(8'd1, p, 7, 0);
    exp_q.push_back(8'h55); exp_q.push_back(8'hBB); exp_q.push_back(8'h03); exp_q.push_back(8'h00);
    exp_q.push_back(8'h3F); exp_q.push_back(8'hF0);
    run_expect(8'd0, make_payload(8'h44), 6, 0);

    for (int v = 0; v < 8; v++) begin
      p          = make_payload(vecs[v].seed);
      stall_at   = vecs[v].stall_at;
      stall_left = vecs[v].stall_len;
      push_model(vecs[v].exp_len_byte, p);
      run_expect(vecs[v].len, p, vecs[v].exp_total, vecs[v].stall_len);
      stall_at = -1;
    end

    // Start during SEND, then start in the DONE cycle held into IDLE.
    acc_cyc.delete();
    r0 = drop_cnt;
    d0 = done_cnt;
    p  = make_payload(8'h21);
    push_model(8'd3, p);
    applyStimulus(8'd3, p);
    repeat (2) @(posedge clk);
    #1;
    start   = 1'b1;
    len     = 8'd9;
    payload = make_payload(8'hEE);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    checkOutput("first_frame_len", acc_cyc.size(), 9);
    acc_cyc.delete();
    p = make_payload(8'h5A);
    push_model(8'd2, p);
    start   = 1'b1;
    len     = 8'd2;
    payload = p;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drop_pulses", drop_cnt - r0, 2);
    checkOutput("done_pulses2", done_cnt - d0, 2);
    checkOutput("second_frame_len", acc_cyc.size(), 8);
    checkOutput("sb_left2", exp_q.size(), 0);
    exp_q.delete();

    // Reset asserted while payload byte 10 is on the bus.
    acc_cyc.delete();
    d0 = done_cnt;
    p  = make_payload(8'h6C);
    push_model(8'd20, p);
    applyStimulus(8'd20, p);
    i = 0;
    while (acc_cyc.size() < 14 && i < 100) begin
      @(posedge clk); #2;
      i++;
    end
    checkOutput("abort_reached", 32'(i < 100), 32'(1));
    checkOutput("abort_byte", 32'(wr_data), 32'(p[10*8 +: 8]));
    reset = 1'b0;
    #1;
    checkOutput("abort_wr_en", 32'(wr_en), 32'(0));
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_data", 32'(wr_data), 32'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("no_resume", 32'(wr_en), 32'(0));
    checkOutput("no_done", done_cnt - d0, 0);
    p = make_payload(8'h19);
    push_model(8'd26, p);
    run_expect(8'd26, p, 32, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
